pc_seq: RTL and testbench
=========================

# pc_seq

Parametrised program-counter sequencer for the PIC16C5x core, the successor to the fixed 9-bit PC unit. It supports up to 2^PC_WIDTH words of program space through STATUS page bits and owns a hardware return stack of configurable depth with overflow/underflow detection. It also generates the skip/flush pair that turns the prefetched instruction into a NOP. The unit sits between the decode/execute sequencer, which supplies the Q-phase strobes and decoded op, and instruction fetch, which consumes `pc`.

## Interface
Parameters:
- PC_WIDTH, 11: program counter width; must be ≥ 9.
- PAGE_BITS, PC_WIDTH-9: number of STATUS page-select bits used; 0 is allowed.
- STACK_DEPTH, 2: return-stack entries; must be ≥ 1.
- RESET_VECTOR, {PC_WIDTH{1'b1}}: value loaded into `pc` on reset.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset; synchronous, active-low.
- q1, in, 1: fetch-Q1 strobe (one clk wide).
- q4, in, 1: execute-Q4 strobe (one clk wide).
- op, in, 3: decoded Q4 op. NONE=0, GOTO=1, CALL=2, RETLW=3, SKIP=4, PCLW=5; codes 6-7 act as NONE.
- skip_cond, in, 1: for op SKIP, a 1 requests a skip (ALU zero, or tested bit matching).
- tgt, in, 9: IR[8:0].
- pcl_data, in, 8: data being written to PCL.
- pa, in, max(PAGE_BITS,1): STATUS page bits.
- pc, out, PC_WIDTH: current program counter.
- flush, out, 1: the next Q1 must not increment `pc`.
- skip, out, 1: the prefetched instruction executes as a NOP.
- sp, out, $clog2(STACK_DEPTH+1): number of valid stack entries.
- stk_ovf, out, 1: sticky flag, set on a push while full.
- stk_unf, out, 1: sticky flag, set on a pop while empty.

## Operation
- Page formation: `page` = `pa[PAGE_BITS-1:0]`, placed at pc[PC_WIDTH-1:9]. With PAGE_BITS=0 the upper field is absent.
- On `q1`:
  - If `flush` is 0, `pc` ← `pc`+1, wrapping modulo 2^PC_WIDTH.
  - Clear `flush` and `skip` on every `q1`.
- On `q4`, by op:
  - GOTO: `pc` ← {page, tgt[8:0]}. Set `flush` and `skip`.
  - CALL: push `pc` (already the return address). Then `pc` ← {page, 1'b0, tgt[7:0]}. Set `flush` and `skip`.
  - RETLW: `pc` ← s[0], then pop. Set `flush` and `skip`.
  - SKIP: if `skip_cond` is 1, set `skip` only; `pc` and `flush` are unchanged.
  - PCLW: `pc` ← {page, 1'b0, pcl_data}. Set `flush` and `skip`.
  - NONE: no effect.
- Stack behaviour:
  - Push: s[i] ← s[i-1], s[0] ← `pc`. `sp` saturates at STACK_DEPTH. If the stack is already full, the oldest entry is lost and `stk_ovf` is set.
  - Pop: s[i] ← s[i+1], and the bottom entry is retained (it duplicates, as on the 16C5x). `sp` saturates at 0. If `sp` is 0, `stk_unf` is set and the stale s[0] is still used.
- Simultaneous `q1` and `q4` is illegal. If it occurs, only the `q4` action applies and `q1` is ignored.

## Timing
- All outputs are registered and update on the clk edge on which the strobe is sampled. Latency is 1 clk.
- Reset values:
  - `pc` = RESET_VECTOR.
  - `flush`, `skip`, `stk_ovf`, `stk_unf` = 0.
  - `sp` = 0.
  - Stack contents = 0.
- Reset has priority over everything and aborts any in-flight op. Flags are cleared only by reset.
- A branch taken at Q4 of cycle N:
  - Q1 of cycle N+1 holds `pc` at the target and clears `flush`/`skip`.
  - Q1 of cycle N+2 increments to target+1.
- Strobes outside Q1/Q4, and ops without `q4`, have no effect.

## Structure
- Shared package `pic_pkg`: op enum (PC_OP_NONE…PC_OP_PCLW), PCL address constant, and the default PC_WIDTH/STACK_DEPTH.
- Sub-module `pc_hw_stack` (parameters STACK_DEPTH, PC_WIDTH) owns the shift array, `sp`, `stk_ovf` and `stk_unf`. It takes push/pop/din and provides dout = s[0].
- `pc_seq` contains the PC register, page mux, flush/skip flags and op decode.

## Test plan
- Reset then Q1 sequence: RESET_VECTOR=11'h7FF. After reset `pc`=7FF; one `q1` gives 000 (wrap); a second `q1` gives 001.
- GOTO with pa=2'b01 and tgt=9'h155: `pc`=11'h355 and `flush`=`skip`=1. The next `q1` keeps 355 and clears both flags. The following `q1` gives 356.
- CALL at pc=0x020, pa=0, tgt=0x1C3: `pc`=0x0C3 (bit 8 cleared), `sp`=1, s[0]=0x020. RETLW then gives `pc`=0x020 and `sp`=0.
- Depth 2: three CALLs from pcs A, B, C: `stk_ovf`=1, `sp`=2, and A is lost. Three RETLWs return C, B, B; the third sets `stk_unf`.
- PCLW with pcl_data=0x80 and pa=2'b10: `pc`=0x480 and `flush`=1. SKIP with `skip_cond`=1: `skip`=1, `flush`=0, and the next `q1` increments normally.
- Reset asserted mid-branch, with `flush`=1 and `sp`=2: every output returns to its reset value on the same edge.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC16C5x core slice.
//   pc_op_e          : decoded Q4 program-counter operation (codes 6-7 behave as NONE)
//   PCL_ADDR         : register-file address of PCL
//   PC_WIDTH_DEF     : default program counter width
//   STACK_DEPTH_DEF  : default hardware return-stack depth
package pic_pkg;

   typedef enum logic [2:0] {
      PC_OP_NONE  = 3'd0,
      PC_OP_GOTO  = 3'd1,
      PC_OP_CALL  = 3'd2,
      PC_OP_RETLW = 3'd3,
      PC_OP_SKIP  = 3'd4,
      PC_OP_PCLW  = 3'd5
   } pc_op_e;

   localparam logic [4:0] PCL_ADDR        = 5'h02;
   localparam int         PC_WIDTH_DEF    = 11;
   localparam int         STACK_DEPTH_DEF = 2;

endpackage

// File: rtl/pc_seq_if.sv
// Bus between the decode/execute sequencer and the PC sequencer.
//   master : drives q1, q4, op, skip_cond, tgt, pcl_data, pa; observes the PC state
//   slave  : the PC sequencer; drives pc, flush, skip, sp, stk_ovf, stk_unf
interface pc_seq_if import pic_pkg::*; #(
   parameter int PC_WIDTH    = PC_WIDTH_DEF,
   parameter int PAGE_BITS   = PC_WIDTH - 9,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF
);
   localparam int PA_W = (PAGE_BITS > 0) ? PAGE_BITS : 1;
   localparam int SP_W = $clog2(STACK_DEPTH + 1);

   logic                q1;
   logic                q4;
   logic [2:0]          op;
   logic                skip_cond;
   logic [8:0]          tgt;
   logic [7:0]          pcl_data;
   logic [PA_W-1:0]     pa;
   logic [PC_WIDTH-1:0] pc;
   logic                flush;
   logic                skip;
   logic [SP_W-1:0]     sp;
   logic                stk_ovf;
   logic                stk_unf;

   modport master (
      output q1, q4, op, skip_cond, tgt, pcl_data, pa,
      input  pc, flush, skip, sp, stk_ovf, stk_unf
   );

   modport slave (
      input  q1, q4, op, skip_cond, tgt, pcl_data, pa,
      output pc, flush, skip, sp, stk_ovf, stk_unf
   );

endinterface

// File: rtl/pc_hw_stack.sv
// Hardware return stack (shift-register style, 16C5x semantics).
//   clk, rst_n : clock, synchronous active-low reset
//   push, pop  : one-cycle requests (never both at once)
//   din        : value pushed into s[0]
//   dout       : current top entry s[0]
//   sp         : number of valid entries, saturating at 0 and STACK_DEPTH
//   stk_ovf    : sticky, push while full (oldest entry dropped)
//   stk_unf    : sticky, pop while empty (stale s[0] still returned)
module pc_hw_stack import pic_pkg::*; #(
   parameter int  STACK_DEPTH = STACK_DEPTH_DEF,
   parameter int  PC_WIDTH    = PC_WIDTH_DEF,
   localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic                pop,
   input  logic [PC_WIDTH-1:0] din,
   output logic [PC_WIDTH-1:0] dout,
   output logic [SP_W-1:0]     sp,
   output logic                stk_ovf,
   output logic                stk_unf
);

   logic [PC_WIDTH-1:0] s [STACK_DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < STACK_DEPTH; i++) s[i] <= '0;
         sp      <= '0;
         stk_ovf <= 1'b0;
         stk_unf <= 1'b0;
      end else if (push) begin
         s[0] <= din;
         for (int i = 1; i < STACK_DEPTH; i++) s[i] <= s[i-1];
         if (sp == SP_W'(STACK_DEPTH)) stk_ovf <= 1'b1;
         else                          sp      <= sp + SP_W'(1);
      end else if (pop) begin
         // Bottom entry is not overwritten, so it duplicates upward.
         for (int i = 0; i < STACK_DEPTH - 1; i++) s[i] <= s[i+1];
         if (sp == '0) stk_unf <= 1'b1;
         else          sp      <= sp - SP_W'(1);
      end
   end

   assign dout = s[0];

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer for the PIC16C5x core.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : pc_seq_if slave; Q-phase strobes, decoded op and operands in,
//                pc / flush / skip / stack status out (all registered)
module pc_seq import pic_pkg::*; #(
   parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
   parameter int                  PAGE_BITS    = PC_WIDTH - 9,
   parameter int                  STACK_DEPTH  = STACK_DEPTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b1}}
) (
   input logic     clk,
   input logic     rst_n,
   pc_seq_if.slave bus
);

   logic [PC_WIDTH-1:0] pcReg, pcNext;
   logic                flushReg, flushNext;
   logic                skipReg, skipNext;
   logic                stkPush, stkPop;
   logic [PC_WIDTH-1:0] stkDout;
   logic [PC_WIDTH-1:0] pageBase;

   // Page bits land at pc[PC_WIDTH-1:9]; any unused upper bits stay zero.
   if (PAGE_BITS == 0) begin : genNoPage
      assign pageBase = '0;
   end else begin : genPage
      assign pageBase = PC_WIDTH'(bus.pa[PAGE_BITS-1:0]) << 9;
   end

   always_comb begin
      pcNext    = pcReg;
      flushNext = flushReg;
      skipNext  = skipReg;
      stkPush   = 1'b0;
      stkPop    = 1'b0;
      // q4 wins if both strobes ever arrive together.
      if (bus.q4) begin
         case (bus.op)
            PC_OP_GOTO: begin
               pcNext    = pageBase | PC_WIDTH'(bus.tgt);
               flushNext = 1'b1;
               skipNext  = 1'b1;
            end
            PC_OP_CALL: begin
               // pc already holds the return address at Q4.
               stkPush   = 1'b1;
               pcNext    = pageBase | PC_WIDTH'(bus.tgt[7:0]);
               flushNext = 1'b1;
               skipNext  = 1'b1;
            end
            PC_OP_RETLW: begin
               stkPop    = 1'b1;
               pcNext    = stkDout;
               flushNext = 1'b1;
               skipNext  = 1'b1;
            end
            PC_OP_SKIP: begin
               if (bus.skip_cond) skipNext = 1'b1;
            end
            PC_OP_PCLW: begin
               pcNext    = pageBase | PC_WIDTH'(bus.pcl_data);
               flushNext = 1'b1;
               skipNext  = 1'b1;
            end
            default: ;
         endcase
      end else if (bus.q1) begin
         if (!flushReg) pcNext = pcReg + PC_WIDTH'(1);
         flushNext = 1'b0;
         skipNext  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcReg    <= RESET_VECTOR;
         flushReg <= 1'b0;
         skipReg  <= 1'b0;
      end else begin
         pcReg    <= pcNext;
         flushReg <= flushNext;
         skipReg  <= skipNext;
      end
   end

   pc_hw_stack #(
      .STACK_DEPTH (STACK_DEPTH),
      .PC_WIDTH    (PC_WIDTH)
   ) uStack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (stkPush),
      .pop     (stkPop),
      .din     (pcReg),
      .dout    (stkDout),
      .sp      (bus.sp),
      .stk_ovf (bus.stk_ovf),
      .stk_unf (bus.stk_unf)
   );

   assign bus.pc    = pcReg;
   assign bus.flush = flushReg;
   assign bus.skip  = skipReg;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed steps from the test plan followed
// by randomized strobes/ops, all compared against a queue-based reference model.
module tb_pc_seq;
   import pic_pkg::*;

   localparam int          PCW = 11;
   localparam int          PB  = 2;
   localparam int          SD  = 2;
   localparam logic [10:0] RV  = 11'h7FF;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pc_seq_if #(.PC_WIDTH(PCW), .PAGE_BITS(PB), .STACK_DEPTH(SD)) bus ();

   pc_seq #(
      .PC_WIDTH     (PCW),
      .PAGE_BITS    (PB),
      .STACK_DEPTH  (SD),
      .RESET_VECTOR (RV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model: front of mStk is the top entry; the queue always holds SD slots.
   int mPc;
   int mSp;
   bit mFlush, mSkip, mOvf, mUnf;
   int mStk[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mPc = int'(RV); mSp = 0;
      mFlush = 0; mSkip = 0; mOvf = 0; mUnf = 0;
      mStk.delete();
      for (int i = 0; i < SD; i++) mStk.push_back(0);
   endtask

   task automatic modelStep(input bit r, input bit s1, input bit s4, input int op,
                            input bit sc, input int tgt, input int pcl, input int pa);
      int base;
      int ret;
      int bottom;
      base = pa * 512;
      if (!r) modelReset();
      else if (s4) begin
         case (op)
            1: begin mPc = (base + tgt) % 2048; mFlush = 1; mSkip = 1; end
            2: begin
               mStk.push_front(mPc);
               void'(mStk.pop_back());
               if (mSp == SD) mOvf = 1; else mSp++;
               mPc = base + (tgt % 256); mFlush = 1; mSkip = 1;
            end
            3: begin
               bottom = mStk[SD-1];
               ret = mStk.pop_front();
               mStk.push_back(bottom);
               if (mSp == 0) mUnf = 1; else mSp--;
               mPc = ret; mFlush = 1; mSkip = 1;
            end
            4: if (sc) mSkip = 1;
            5: begin mPc = base + pcl; mFlush = 1; mSkip = 1; end
            default: ;
         endcase
      end else if (s1) begin
         if (!mFlush) mPc = (mPc + 1) % 2048;
         mFlush = 0; mSkip = 0;
      end
   endtask

   task automatic checkModel(input string tag);
      chk({tag, ".pc"},    32'(bus.pc),      32'(mPc));
      chk({tag, ".flush"}, 32'(bus.flush),   32'(mFlush));
      chk({tag, ".skip"},  32'(bus.skip),    32'(mSkip));
      chk({tag, ".sp"},    32'(bus.sp),      32'(mSp));
      chk({tag, ".ovf"},   32'(bus.stk_ovf), 32'(mOvf));
      chk({tag, ".unf"},   32'(bus.stk_unf), 32'(mUnf));
   endtask

   task automatic step(input string tag, input bit r, input bit s1, input bit s4, input int op,
                       input bit sc, input int tgt, input int pcl, input int pa);
      rst_n         = r;
      bus.q1        = s1;
      bus.q4        = s4;
      bus.op        = 3'(op);
      bus.skip_cond = sc;
      bus.tgt       = 9'(tgt);
      bus.pcl_data  = 8'(pcl);
      bus.pa        = 2'(pa);
      modelStep(r, s1, s4, op, sc, tgt, pcl, pa);
      @(posedge clk);
      #1;
      bus.q1 = 1'b0;
      bus.q4 = 1'b0;
      rst_n  = 1'b1;
      checkModel(tag);
   endtask

   task automatic q1Step(input string tag);
      step(tag, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
   endtask

   task automatic q4Step(input string tag, input int op, input int tgt, input int pa,
                         input int pcl, input bit sc);
      step(tag, 1'b1, 1'b0, 1'b1, op, sc, tgt, pcl, pa);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.q1 = 1'b0; bus.q4 = 1'b0; bus.op = 3'd0; bus.skip_cond = 1'b0;
      bus.tgt = 9'd0; bus.pcl_data = 8'd0; bus.pa = 2'd0;
      modelReset();

      // Reset, then Q1 wrap and increment
      step("rst0", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
      step("rst1", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
      chk("rst_pc", 32'(bus.pc), 32'h7FF);
      chk("rst_sp", 32'(bus.sp), 32'h0);
      q1Step("q1wrap");
      chk("wrap_pc", 32'(bus.pc), 32'h000);
      q1Step("q1inc");
      chk("inc_pc", 32'(bus.pc), 32'h001);

      // GOTO with page 1
      q4Step("goto", 1, 9'h155, 1, 0, 1'b0);
      chk("goto_pc", 32'(bus.pc), 32'h355);
      chk("goto_flush", 32'(bus.flush), 32'h1);
      chk("goto_skip", 32'(bus.skip), 32'h1);
      q1Step("goto_q1a");
      chk("goto_hold", 32'(bus.pc), 32'h355);
      chk("goto_clr", 32'({bus.flush, bus.skip}), 32'h0);
      q1Step("goto_q1b");
      chk("goto_next", 32'(bus.pc), 32'h356);

      // CALL / RETLW
      q4Step("to020", 1, 9'h020, 0, 0, 1'b0);
      q1Step("to020_q1");
      q4Step("call", 2, 9'h1C3, 0, 0, 1'b0);
      chk("call_pc", 32'(bus.pc), 32'h0C3);
      chk("call_sp", 32'(bus.sp), 32'h1);
      q1Step("call_q1");
      q4Step("ret", 3, 0, 0, 0, 1'b0);
      chk("ret_pc", 32'(bus.pc), 32'h020);
      chk("ret_sp", 32'(bus.sp), 32'h0);
      q1Step("ret_q1");

      // Overflow then underflow at depth 2: A=010 B=050 C=060
      q4Step("toA", 1, 9'h010, 0, 0, 1'b0);
      q1Step("toA_q1");
      q4Step("callA", 2, 9'h050, 0, 0, 1'b0);
      q1Step("callA_q1");
      q4Step("callB", 2, 9'h060, 0, 0, 1'b0);
      q1Step("callB_q1");
      q4Step("callC", 2, 9'h070, 0, 0, 1'b0);
      chk("ovf_flag", 32'(bus.stk_ovf), 32'h1);
      chk("ovf_sp", 32'(bus.sp), 32'h2);
      q1Step("callC_q1");
      q4Step("ret1", 3, 0, 0, 0, 1'b0);
      chk("ret1_pc", 32'(bus.pc), 32'h060);
      q1Step("ret1_q1");
      q4Step("ret2", 3, 0, 0, 0, 1'b0);
      chk("ret2_pc", 32'(bus.pc), 32'h050);
      chk("ret2_unf", 32'(bus.stk_unf), 32'h0);
      q1Step("ret2_q1");
      q4Step("ret3", 3, 0, 0, 0, 1'b0);
      chk("ret3_pc", 32'(bus.pc), 32'h050);
      chk("ret3_unf", 32'(bus.stk_unf), 32'h1);
      q1Step("ret3_q1");

      // PCLW with page 2, then SKIP
      q4Step("pclw", 5, 0, 2, 8'h80, 1'b0);
      chk("pclw_pc", 32'(bus.pc), 32'h480);
      chk("pclw_flush", 32'(bus.flush), 32'h1);
      q1Step("pclw_q1");
      q4Step("skip", 4, 0, 0, 0, 1'b1);
      chk("skip_skip", 32'(bus.skip), 32'h1);
      chk("skip_flush", 32'(bus.flush), 32'h0);
      chk("skip_pc", 32'(bus.pc), 32'h480);
      q1Step("skip_q1");
      chk("skip_next", 32'(bus.pc), 32'h481);

      // Reset in the middle of a branch with a full stack
      q4Step("fill1", 2, 9'h030, 0, 0, 1'b0);
      q1Step("fill1_q1");
      q4Step("fill2", 2, 9'h040, 0, 0, 1'b0);
      chk("fill_sp", 32'(bus.sp), 32'h2);
      chk("fill_flush", 32'(bus.flush), 32'h1);
      step("midrst", 1'b0, 1'b0, 1'b1, 1, 1'b0, 9'h1AA, 0, 3);
      chk("midrst_pc", 32'(bus.pc), 32'h7FF);
      chk("midrst_flags", 32'({bus.flush, bus.skip, bus.stk_ovf, bus.stk_unf}), 32'h0);
      chk("midrst_sp", 32'(bus.sp), 32'h0);

      // Randomized strobes and ops, including illegal q1+q4 and rare resets
      for (int n = 0; n < 400; n++) begin
         int kind;
         bit r, s1, s4;
         kind = int'($urandom_range(9));
         r  = ($urandom_range(99) != 0);
         s1 = (kind <= 3) || (kind == 9);
         s4 = (kind >= 4);
         step($sformatf("rnd%0d", n), r, s1, s4, int'($urandom_range(7)),
              1'($urandom_range(1)), int'($urandom_range(511)),
              int'($urandom_range(255)), int'($urandom_range(3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
